// File: rtl/drrip_meta_ctrl.sv
// drrip_meta_ctrl: per-set RRPV row store with PSEL set-dueling policy select for the DRRIP replacement unit
// Optional leader-miss counters are enabled with DRRIP_PERF_CNT_EN.
module drrip_meta_ctrl #(
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_SIZE      = 2,
  parameter int INDEX_WIDTH   = 5,
  parameter int DEPTH         = 32,
  parameter int M             = 2,
  parameter int PSEL_WIDTH    = 10,
  parameter int LEADER_MOD    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   acc_valid,
  input  logic [INDEX_WIDTH-1:0] acc_index,
  input  logic                   acc_miss,
  output logic                   rd_valid,
  output logic [M-1:0]           rd_entry [ASSOCIATIVITY],
  output logic                   policy_sel,
  input  logic                   wb_valid,
  input  logic [INDEX_WIDTH-1:0] wb_index,
  input  logic [M-1:0]           wb_entry [ASSOCIATIVITY],
  output logic [PSEL_WIDTH-1:0]  psel
`ifdef DRRIP_PERF_CNT_EN
  ,
  output logic [31:0]            srrip_leader_miss_cnt,
  output logic [31:0]            brrip_leader_miss_cnt
`endif
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [INDEX_WIDTH-1:0] LMASK = INDEX_WIDTH'(LEADER_MOD - 1);
  localparam logic [PSEL_WIDTH-1:0] PSEL_MID = {1'b1, {(PSEL_WIDTH-1){1'b0}}};
  state_t state, state_nxt;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [M-1:0] row [ASSOCIATIVITY];
  logic acc_en, wb_en, bypass, lead_s, lead_b, train_s, train_b;
  assign init_done = state == RUN;
  assign acc_en    = acc_valid && init_done;
  assign wb_en     = wb_valid && init_done;
  assign bypass    = wb_en && wb_index == acc_index;
  assign lead_s    = (acc_index & LMASK) == '0;
  assign lead_b    = (acc_index & LMASK) == INDEX_WIDTH'(1);
  assign train_s   = acc_en && acc_miss && lead_s;
  assign train_b   = acc_en && acc_miss && lead_b;
  always_ff @(posedge clk)
    if (!rst_n) state <= INIT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == INIT && ptr == INDEX_WIDTH'(DEPTH - 1)) ? RUN : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (!init_done) ptr <= ptr + 1'b1;
  // one storage column per way; the sweep owns the write port until RUN
  for (genvar w = 0; w < (1 << SET_SIZE); w++) begin : g_way
    logic [M-1:0] mem [DEPTH];
    always_ff @(posedge clk)
      if (rst_n && !init_done) mem[ptr] <= '1;
      else if (rst_n && wb_en) mem[wb_index] <= wb_entry[w];
    assign row[w] = bypass ? wb_entry[w] : mem[acc_index];
  end
  always_ff @(posedge clk)
    if (!rst_n) psel <= PSEL_MID;
    else if (train_s && psel != '1) psel <= psel + 1'b1;
    else if (train_b && psel != '0) psel <= psel - 1'b1;
  // policy for followers uses PSEL before this access's own update
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      policy_sel <= 1'b0;
      rd_entry   <= '{default: '0};
    end else begin
      rd_valid <= acc_en;
      if (acc_en) begin
        rd_entry   <= row;
        policy_sel <= lead_b || (!lead_s && psel[PSEL_WIDTH-1]);
      end
    end
`ifdef DRRIP_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      srrip_leader_miss_cnt <= '0;
      brrip_leader_miss_cnt <= '0;
    end else begin
      if (train_s) srrip_leader_miss_cnt <= srrip_leader_miss_cnt + 1'b1;
      if (train_b) brrip_leader_miss_cnt <= brrip_leader_miss_cnt + 1'b1;
    end
`endif
endmodule
